seq_mul_div: RTL and testbench

- Parametrised sequential signed multiplier/divider; next generation of the team's sequential multiplier.
- Operands enter serially over one shared Data bus. A single start launches either a radix-2 shift-add multiply or a restoring divide, selected by op.
- Adds divide mode, error flagging and a fixed, width-derived latency.
- Sits behind the datapath controller; the controller loads operands and polls ready.

---
 rtl/seq_mul_div.sv | 186 ++++++++++++++++++
 tb/tb_seq_mul_div.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_mul_div.sv
// seq_mul_div: sequential signed multiplier / restoring divider.
// Operands arrive one at a time on Data (first load edge -> A, second -> B).
// A start runs a radix-2 shift-add multiply or a restoring divide. The
// latency is fixed at WORD_LENGTH+2 edges, including the error cases.
// Result holds either the 2W-bit product or {remainder, quotient}.
// Optional build macro SEQ_MUL_DIV_SIGN_SEL_EN adds an is_signed input.
// That input is latched with op and, when 0, selects unsigned operation.
module seq_mul_div #(
    parameter int WORD_LENGTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       load,
    input  logic                       start,
    input  logic                       op,
`ifdef SEQ_MUL_DIV_SIGN_SEL_EN
    input  logic                       is_signed,
`endif
    input  logic [WORD_LENGTH-1:0]     Data,
    output logic                       stored,
    output logic                       busy,
    output logic                       ready,
    output logic                       error,
    output logic [2*WORD_LENGTH-1:0]   Result
);
    localparam int W  = WORD_LENGTH;
    localparam int CW = (W > 2) ? $clog2(W) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(W - 1);
    localparam logic [W-1:0]  MIN_VAL  = {1'b1, {(W-1){1'b0}}};

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] PREP = 3'd1;
    localparam logic [2:0] CALC = 3'd2;
    localparam logic [2:0] FIX  = 3'd3;
    localparam logic [2:0] DONE = 3'd4;

    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic          load_d;
    logic          ptr_b;        // 0: next capture goes to A, 1: to B
    logic [W-1:0]  a_reg, b_reg;
    logic          op_r, sgn_r;

    // Shared datapath: multiply uses {rem,quo} as the shifting product with
    // opnd = |A|. Divide uses rem as the partial remainder, quo as the
    // dividend/quotient shifter, and opnd = |B|.
    logic [W:0]    rem;
    logic [W-1:0]  quo, opnd;
    logic          neg_r, a_neg_r, dz_r, err_r;

    logic          sgn_in;
`ifdef SEQ_MUL_DIV_SIGN_SEL_EN
    assign sgn_in = is_signed;
`else
    assign sgn_in = 1'b1;
`endif

    logic load_edge, start_acc, capture;
    assign load_edge = load & ~load_d & ~busy;
    assign start_acc = start & stored & ~busy;
    // A start accepted in the same cycle wins, so the operands stay frozen
    assign capture   = load_edge & ~start_acc;

    logic         a_neg, b_neg;
    logic [W-1:0] abs_a, abs_b;
    assign a_neg = sgn_r & a_reg[W-1];
    assign b_neg = sgn_r & b_reg[W-1];
    // -MIN wraps back to the MIN bit pattern, which read unsigned is 2^(W-1)
    assign abs_a = a_neg ? -a_reg : a_reg;
    assign abs_b = b_neg ? -b_reg : b_reg;

    logic [W:0]   shifted, sum;
    logic [W-1:0] addend;
    logic         div_ge;
    assign shifted = {rem[W-1:0], quo[W-1]};
    assign div_ge  = shifted >= {1'b0, opnd};
    assign addend  = quo[0] ? opnd : '0;
    assign sum     = rem + {1'b0, addend};

    logic [2*W-1:0] mag, prod;
    logic [W-1:0]   q_fix, r_fix;
    assign mag   = {rem[W-1:0], quo};
    assign prod  = neg_r ? -mag : mag;
    // On divide by zero the quotient is forced to all ones and the
    // remainder to the raw dividend, whatever the sign handling produced
    assign q_fix = dz_r ? '1    : (neg_r   ? -quo        : quo);
    assign r_fix = dz_r ? a_reg : (a_neg_r ? -rem[W-1:0] : rem[W-1:0]);

    // Control: load-edge capture, operand pointer, FSM sequencing and handshake flags
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            load_d <= 1'b0;
            ptr_b  <= 1'b0;
            a_reg  <= '0;
            b_reg  <= '0;
            op_r   <= 1'b0;
            sgn_r  <= 1'b0;
            stored <= 1'b0;
            busy   <= 1'b0;
            ready  <= 1'b0;
        end else begin
            load_d <= load;
            case (state)
                IDLE, DONE: begin
                    if (start_acc) begin
                        state  <= PREP;
                        busy   <= 1'b1;
                        ready  <= 1'b0;
                        stored <= 1'b0;
                        op_r   <= op;
                        sgn_r  <= sgn_in;
                    end else if (capture) begin
                        state <= IDLE;
                        ready <= 1'b0;
                        ptr_b <= ~ptr_b;
                        if (ptr_b) begin
                            b_reg  <= Data;
                            stored <= 1'b1;
                        end else begin
                            a_reg  <= Data;
                            stored <= 1'b0;
                        end
                    end
                end
                PREP: begin
                    state <= CALC;
                    cnt   <= '0;
                end
                CALC: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_CNT) state <= FIX;
                end
                FIX: begin
                    state <= DONE;
                    busy  <= 1'b0;
                    ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Datapath: magnitude/sign prep, one multiply or divide step per CALC cycle, sign fix into Result
    always_ff @(posedge clk) begin
        if (reset) begin
            rem     <= '0;
            quo     <= '0;
            opnd    <= '0;
            neg_r   <= 1'b0;
            a_neg_r <= 1'b0;
            dz_r    <= 1'b0;
            err_r   <= 1'b0;
            error   <= 1'b0;
            Result  <= '0;
        end else begin
            case (state)
                PREP: begin
                    rem     <= '0;
                    quo     <= op_r ? abs_a : abs_b;
                    opnd    <= op_r ? abs_b : abs_a;
                    neg_r   <= a_neg ^ b_neg;
                    a_neg_r <= a_neg;
                    dz_r    <= op_r & (b_reg == '0);
                    err_r   <= op_r & ((b_reg == '0) |
                                       (sgn_r & (a_reg == MIN_VAL) & (b_reg == '1)));
                end
                CALC: begin
                    if (op_r) begin
                        rem <= div_ge ? (shifted - {1'b0, opnd}) : shifted;
                        quo <= {quo[W-2:0], div_ge};
                    end else begin
                        rem <= {1'b0, sum[W:1]};
                        quo <= {sum[0], quo[W-1:1]};
                    end
                end
                FIX: begin
                    Result <= op_r ? {r_fix, q_fix} : prod;
                    error  <= err_r;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_mul_div.sv
// Testbench for seq_mul_div at WORD_LENGTH=5. The stimulus process pushes
// expectations from an integer-arithmetic model, and a negedge monitor pops
// one expectation on every rising edge of ready.
module tb_seq_mul_div;
    localparam int W = 5;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           load = 1'b0;
    logic           start = 1'b0;
    logic           op = 1'b0;
    logic [W-1:0]   Data = '0;
    logic           stored, busy, ready, error;
    logic [2*W-1:0] Result;

    seq_mul_div #(.WORD_LENGTH(W)) dut (
        .clk(clk), .reset(reset), .load(load), .start(start), .op(op),
        .Data(Data), .stored(stored), .busy(busy), .ready(ready),
        .error(error), .Result(Result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    typedef struct {
        logic [2*W-1:0] res;
        logic           err;
        int             t0;
    } exp_t;

    exp_t sbq[$];
    int checks = 0;
    int errors = 0;

    // bench-side view of the operand registers
    logic [W-1:0] ma = '0, mb = '0;
    logic         mptr = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: plain signed integer arithmetic
    function automatic logic [2*W:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic o);
        int sa, sb, p, q, r;
        logic [2*W-1:0] res;
        logic e;
        sa = int'($signed(a));
        sb = int'($signed(b));
        e = 1'b0;
        if (!o) begin
            p = sa * sb;
            res = p[2*W-1:0];
        end else if (sb == 0) begin
            e = 1'b1;
            res = {a, {W{1'b1}}};
        end else if (sa == -(1 << (W-1)) && sb == -1) begin
            e = 1'b1;
            q = -(1 << (W-1));
            res = {{W{1'b0}}, q[W-1:0]};
        end else begin
            q = sa / sb;
            r = sa % sb;
            res = {r[W-1:0], q[W-1:0]};
        end
        return {e, res};
    endfunction

    task automatic load_op(input logic [W-1:0] v);
        @(negedge clk); load = 1'b1; Data = v;
        @(negedge clk); load = 1'b0;
        if (!mptr) ma = v; else mb = v;
        mptr = ~mptr;
    endtask

    task automatic load_hold(input logic [W-1:0] v);
        @(negedge clk); load = 1'b1; Data = v;
        repeat (3) @(negedge clk);
        load = 1'b0;
        if (!mptr) ma = v; else mb = v;
        mptr = ~mptr;
    endtask

    task automatic do_start(input logic o);
        logic [2*W:0] m;
        exp_t e;
        @(negedge clk); start = 1'b1; op = o;
        m = model(ma, mb, o);
        e.res = m[2*W-1:0];
        e.err = m[2*W];
        e.t0  = cyc + 1;
        sbq.push_back(e);
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (sbq.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout pending=%0d", sbq.size());
            sbq.delete();
        end
    endtask

    // Monitor: one expectation consumed per rising edge of ready
    exp_t mon_e;
    logic rdy_prev = 1'b0;
    always @(negedge clk) begin
        if (ready && !rdy_prev) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ready actual Result=%0h expected no result", Result);
            end else begin
                mon_e = sbq.pop_front();
                chk("result",  32'(Result), 32'(mon_e.res));
                chk("error",   32'(error),  32'(mon_e.err));
                chk("latency", 32'(cyc - mon_e.t0), 32'(W + 2));
            end
        end
        rdy_prev = ready;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] ra, rb;
        int sel;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_stored", 32'(stored), 0);
        chk("rst_busy",   32'(busy),   0);
        chk("rst_ready",  32'(ready),  0);
        chk("rst_error",  32'(error),  0);
        chk("rst_result", 32'(Result), 0);
        reset = 1'b0;

        // signed multiply -13 * 11
        load_op(5'(-13));
        chk("stored_after_a", 32'(stored), 0);
        load_op(5'd11);
        chk("stored_after_b", 32'(stored), 1);
        do_start(1'b0);
        chk("busy_after_start",   32'(busy),   1);
        chk("stored_after_start", 32'(stored), 0);
        wait_done();

        // signed divide -13 / 11
        load_op(5'(-13)); load_op(5'd11); do_start(1'b1); wait_done();

        // divide by zero; Result and ready hold in DONE
        load_op(5'd7); load_op(5'd0); do_start(1'b1); wait_done();
        repeat (3) @(negedge clk);
        chk("done_hold_ready",  32'(ready),  1);
        chk("done_hold_result", 32'(Result), 32'h0FF);

        // extremes
        load_op(5'(-16)); load_op(5'(-1));  do_start(1'b1); wait_done();
        load_op(5'(-16)); load_op(5'(-16)); do_start(1'b0); wait_done();

        // start with one operand is ignored; the load edge clears ready
        load_op(5'd3);
        chk("load_clears_ready", 32'(ready), 0);
        @(negedge clk); start = 1'b1; op = 1'b0;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        chk("one_operand_busy", 32'(busy), 0);
        load_op(5'd5); do_start(1'b0); wait_done();

        // load edge while busy is ignored (model operands untouched)
        load_op(5'd6); load_op(5'd7); do_start(1'b1);
        @(negedge clk); load = 1'b1; Data = 5'd9;
        @(negedge clk); load = 1'b0;
        wait_done();
        chk("stored_after_done", 32'(stored), 0);
        load_op(5'(-9)); load_op(5'd2); do_start(1'b0); wait_done();

        // load held high counts once
        load_hold(5'(-5)); load_op(5'd4); do_start(1'b0); wait_done();
        load_hold(5'd13);  load_hold(5'(-3)); do_start(1'b1); wait_done();

        // reset during the third CALC cycle
        load_op(5'd9); load_op(5'd3); do_start(1'b1);
        sbq.delete();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        mptr = 1'b0; ma = '0; mb = '0;
        chk("midrst_busy",   32'(busy),   0);
        chk("midrst_ready",  32'(ready),  0);
        chk("midrst_stored", 32'(stored), 0);
        chk("midrst_error",  32'(error),  0);
        chk("midrst_result", 32'(Result), 0);
        load_op(5'd9); load_op(5'd3); do_start(1'b1); wait_done();

        // randomized operations
        for (int i = 0; i < 60; i++) begin
            ra  = 5'($urandom);
            rb  = 5'($urandom);
            sel = int'($urandom_range(0, 7));
            if (sel == 0) rb = '0;
            if (sel == 1) begin ra = 5'b10000; rb = 5'b11111; end
            load_op(ra);
            load_op(rb);
            do_start(1'($urandom_range(0, 1)));
            wait_done();
        end

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
